// File: rtl/strip_placement_ctrl_pkg.sv
// Shared parameters and FSM encoding for the strip placement controller.
package strip_placement_ctrl_pkg;

  localparam int unsigned NumStrips = 8;
  localparam int unsigned StripCap  = 128;
  localparam int unsigned OccW      = 8;
  localparam int unsigned WidW      = 5;
  localparam int unsigned SidxW     = $clog2(NumStrips);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StCheck = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/strip_placement_ctrl_strike_det.sv
// Add/compare for the placement check: sum of occupancy and width, strike if over capacity.
module strip_placement_ctrl_strike_det
  import strip_placement_ctrl_pkg::*;
(
  input  logic [OccW-1:0] occ_i,
  input  logic [WidW-1:0] width_i,
  output logic [OccW-1:0] sum_o,
  output logic            strike_o
);

  logic [OccW:0] sum_full;

  // One extra bit so the sum never wraps; sum_o is only meaningful when no strike.
  always_comb begin
    sum_full = {1'b0, occ_i} + {{(OccW + 1 - WidW){1'b0}}, width_i};
    strike_o = sum_full > (OccW + 1)'(StripCap);
    sum_o    = sum_full[OccW-1:0];
  end

endmodule

// File: rtl/strip_placement_ctrl.sv
// Places blocks onto the least-occupied strip, committing occupancy unless the block would strike.
module strip_placement_ctrl
  import strip_placement_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_all_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WidW-1:0]  req_width_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [SidxW-1:0] rsp_strip_o,
  output logic [OccW-1:0]  rsp_offset_o,
  output logic             rsp_strike_o,
  output logic             busy_o,
  output logic [15:0]      place_cnt_o,
  output logic [15:0]      strike_cnt_o
);

  localparam logic [SidxW-1:0] LastIdx = SidxW'(NumStrips - 1);

  state_e           state_q;
  logic [SidxW-1:0] idx_q, best_q;
  logic [OccW-1:0]  best_occ_q;
  logic [WidW-1:0]  width_q;
  logic [OccW-1:0]  occ_q [NumStrips];
  logic             rsp_valid_q, rsp_strike_q;
  logic [SidxW-1:0] rsp_strip_q;
  logic [OccW-1:0]  rsp_offset_q;
  logic [15:0]      place_cnt_q, strike_cnt_q;

  logic [OccW-1:0]  sum;
  logic             strike;

  strip_placement_ctrl_strike_det u_strike_det (
    .occ_i    (best_occ_q),
    .width_i  (width_q),
    .sum_o    (sum),
    .strike_o (strike)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      best_q       <= '0;
      best_occ_q   <= '0;
      width_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_strike_q <= 1'b0;
      rsp_strip_q  <= '0;
      rsp_offset_q <= '0;
      place_cnt_q  <= '0;
      strike_cnt_q <= '0;
      for (int i = 0; i < NumStrips; i++) occ_q[i] <= '0;
    end else if (clear_all_i) begin
      // Drops any in-flight request, including a commit due this cycle.
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      for (int i = 0; i < NumStrips; i++) occ_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            width_q    <= req_width_i;
            idx_q      <= '0;
            best_q     <= '0;
            best_occ_q <= occ_q[0];
            state_q    <= StScan;
          end
        end
        StScan: begin
          // Strictly-less keeps the lowest index on ties.
          if (occ_q[idx_q] < best_occ_q) begin
            best_q     <= idx_q;
            best_occ_q <= occ_q[idx_q];
          end
          if (idx_q == LastIdx) state_q <= StCheck;
          else                  idx_q   <= idx_q + SidxW'(1);
        end
        StCheck: begin
          if (!strike) begin
            occ_q[best_q] <= sum;
            if (place_cnt_q != 16'hFFFF) place_cnt_q <= place_cnt_q + 16'd1;
          end else if (strike_cnt_q != 16'hFFFF) begin
            strike_cnt_q <= strike_cnt_q + 16'd1;
          end
          rsp_strip_q  <= best_q;
          rsp_offset_q <= best_occ_q;
          rsp_strike_q <= strike;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle) && !clear_all_i;
  assign busy_o       = (state_q != StIdle);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_strip_o  = rsp_strip_q;
  assign rsp_offset_o = rsp_offset_q;
  assign rsp_strike_o = rsp_strike_q;
  assign place_cnt_o  = place_cnt_q;
  assign strike_cnt_o = strike_cnt_q;

endmodule
